// File: rtl/simple_edge_detect_generate.sv
// rtl/simple_edge_detect_generate.sv - CDC edge-detect source: rotating data word framed by a setup/hold toggle strobe
// Optional feature macro: SIMPLE_EDGE_GEN_ERR_INJECT_EN (injectError corrupts the next word with XOR 0xFF).
module simple_edge_detect_generate #(
   parameter int unsigned SETUP_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES  = 4,
   parameter int unsigned NUM_EDGES    = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        injectError,
   output logic [7:0]  sendData,
   output logic        sendEdge,
   output logic        busy,
   output logic        done,
   output logic [15:0] edgesSent
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HOLD,
      ST_DONE
   } state_t;

   localparam logic [15:0] SETUP_RELOAD = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0] HOLD_RELOAD  = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] RUN_LIMIT    = 16'(NUM_EDGES);
   localparam bit          RUN_LIMITED  = (NUM_EDGES != 0);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  pattern_q, pattern_d;
   logic [7:0]  send_data_q, send_data_d;
   logic        send_edge_q, send_edge_d;
   logic [15:0] edges_sent_q, edges_sent_d;
   logic [15:0] run_edges_q, run_edges_d;
   logic        stop_pend_q, stop_pend_d;
   logic        load_word;

   // Rotation the destination checker expects; anything off-sequence (including 0x00) restarts at 0x81.
   function automatic logic [7:0] next_pattern(input logic [7:0] p);
      logic [7:0] n;
      case (p)
         8'h81:   n = 8'h42;
         8'h42:   n = 8'h24;
         8'h24:   n = 8'h18;
         default: n = 8'h81;
      endcase
      return n;
   endfunction

`ifdef SIMPLE_EDGE_GEN_ERR_INJECT_EN
   logic inject_q, inject_d;
   logic inject_now;

   assign inject_now = inject_q | injectError;

   always_comb begin
      inject_d = inject_now;
      if (load_word) begin
         inject_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         inject_q <= 1'b0;
      end else begin
         inject_q <= inject_d;
      end
   end
`else
   logic unused_inject;
   assign unused_inject = injectError;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pattern_d    = pattern_q;
      send_data_d  = send_data_q;
      send_edge_d  = send_edge_q;
      edges_sent_d = edges_sent_q;
      run_edges_d  = run_edges_q;
      stop_pend_d  = stop_pend_q;
      load_word    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (stop) begin
                  stop_pend_d = 1'b0;
               end else begin
                  load_word = 1'b1;
               end
            end
         end
         ST_SETUP: begin
            if (stop) begin
               stop_pend_d = 1'b1;
            end
            if (cnt_q == 16'd0) begin
               send_edge_d  = ~send_edge_q;
               edges_sent_d = edges_sent_q + 16'd1;
               run_edges_d  = run_edges_q + 16'd1;
               cnt_d        = HOLD_RELOAD;
               state_d      = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_HOLD: begin
            if (stop) begin
               stop_pend_d = 1'b1;
            end
            // A stop arriving on the expiry cycle itself still ends the run here.
            if (cnt_q == 16'd0) begin
               if (stop_pend_q || stop || (RUN_LIMITED && (run_edges_q == RUN_LIMIT))) begin
                  state_d = ST_DONE;
               end else begin
                  load_word = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_DONE: begin
            stop_pend_d = 1'b0;
            run_edges_d = 16'd0;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_word) begin
         pattern_d = next_pattern(pattern_q);
`ifdef SIMPLE_EDGE_GEN_ERR_INJECT_EN
         send_data_d = pattern_d ^ {8{inject_now}};
`else
         send_data_d = pattern_d;
`endif
         cnt_d   = SETUP_RELOAD;
         state_d = ST_SETUP;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 16'd0;
         pattern_q    <= 8'h00;
         send_data_q  <= 8'h00;
         send_edge_q  <= 1'b0;
         edges_sent_q <= 16'd0;
         run_edges_q  <= 16'd0;
         stop_pend_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pattern_q    <= pattern_d;
         send_data_q  <= send_data_d;
         send_edge_q  <= send_edge_d;
         edges_sent_q <= edges_sent_d;
         run_edges_q  <= run_edges_d;
         stop_pend_q  <= stop_pend_d;
      end
   end

   assign sendData  = send_data_q;
   assign sendEdge  = send_edge_q;
   assign edgesSent = edges_sent_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_simple_edge_detect_generate.sv
// tb/tb_simple_edge_detect_generate.sv - scoreboard bench for simple_edge_detect_generate
`timescale 1ns/1ps
module tb_simple_edge_detect_generate;

   localparam int S  = 3;
   localparam int H  = 5;
   localparam int NE = 5;
   localparam int P  = S + H;
`ifdef SIMPLE_EDGE_GEN_ERR_INJECT_EN
   localparam bit INJ_EN = 1'b1;
`else
   localparam bit INJ_EN = 1'b0;
`endif
   localparam int K_DATA = 0;
   localparam int K_EDGE = 1;
   localparam int K_BUSY = 2;
   localparam int K_DONE = 3;

   typedef struct {
      int cyc;
      int kind;
      int val;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        injectError = 1'b0;
   logic [7:0]  sendData;
   logic        sendEdge;
   logic        busy;
   logic        done;
   logic [15:0] edgesSent;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ev_t  evq[$];
   ev_t  mev;
   bit   mon_hold = 1'b1;
   logic [7:0] p_data;
   logic p_edge, p_busy, p_done;

   logic [7:0] rot [4];
   int   mdl_idx = -1;
   int   mdl_edges = 0;
   bit   mdl_lvl = 1'b0;
   bit   mdl_inj = 1'b0;

   simple_edge_detect_generate #(
      .SETUP_CYCLES(S),
      .HOLD_CYCLES (H),
      .NUM_EDGES   (NE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .injectError(injectError),
      .sendData   (sendData),
      .sendEdge   (sendEdge),
      .busy       (busy),
      .done       (done),
      .edgesSent  (edgesSent)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int c, input int k, input int v);
      ev_t e;
      e.cyc = c;
      e.kind = k;
      e.val = v;
      evq.push_back(e);
   endtask

   task automatic expect_ev(input int kind, input int val);
      ev_t e;
      checks++;
      if (evq.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d val=0x%0h at cycle %0d, expected no event", kind, val, cyc);
      end else begin
         e = evq.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.val != val) begin
            errors++;
            $display("FAIL event: got kind=%0d val=0x%0h cycle=%0d, expected kind=%0d val=0x%0h cycle=%0d",
                     kind, val, cyc, e.kind, e.val, e.cyc);
         end
      end
   endtask

   // Monitor: every output change must match the next scoreboard entry.
   always @(negedge clk) begin
      if (!mon_hold) begin
         while (evq.size() > 0 && evq[0].cyc < cyc) begin
            mev = evq.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_event: got nothing by cycle %0d, expected kind=%0d val=0x%0h at cycle %0d",
                     cyc, mev.kind, mev.val, mev.cyc);
         end
         if (sendData != p_data) expect_ev(K_DATA, int'(sendData));
         if (sendEdge != p_edge) expect_ev(K_EDGE, int'(edgesSent));
         if (busy != p_busy)     expect_ev(K_BUSY, int'(busy));
         if (done != p_done)     expect_ev(K_DONE, int'(done));
      end
      p_data = sendData;
      p_edge = sendEdge;
      p_busy = busy;
      p_done = done;
   end

   // One run: predict every event from the word/period rules, then drive the pulses.
   task automatic do_run(input int stop_off, input int inj_off, input int abort_off);
      int T, n, span, L;
      bit inj_used;
      logic [7:0] w;
      @(negedge clk);
      T = cyc + 1;
      n = NE;
      if (stop_off > 0 && (stop_off + P - 1) / P < n) n = (stop_off + P - 1) / P;
      inj_used = 1'b0;
      for (int j = 0; j < n; j++) begin
         L = j * P;
         if (abort_off >= 0 && L >= abort_off) break;
         mdl_idx = (mdl_idx + 1) % 4;
         w = rot[mdl_idx];
         if (INJ_EN && (mdl_inj || (inj_off >= 0 && inj_off <= L && !inj_used))) begin
            w = w ^ 8'hFF;
            mdl_inj = 1'b0;
            if (inj_off >= 0 && inj_off <= L) inj_used = 1'b1;
         end
         push_ev(T + L, K_DATA, int'(w));
         if (j == 0) push_ev(T, K_BUSY, 1);
         if (abort_off >= 0 && L + S >= abort_off) break;
         mdl_edges = (mdl_edges + 1) % 65536;
         mdl_lvl = ~mdl_lvl;
         push_ev(T + L + S, K_EDGE, mdl_edges);
      end
      if (abort_off < 0) begin
         push_ev(T + n * P, K_DONE, 1);
         push_ev(T + n * P + 1, K_BUSY, 0);
         push_ev(T + n * P + 1, K_DONE, 0);
         if (INJ_EN && inj_off >= 0 && !inj_used) mdl_inj = 1'b1;
         span = n * P + 3;
      end else begin
         span = abort_off + 1;
      end

      start = 1'b1;
      injectError = (inj_off == 0);
      for (int off = 1; off <= span; off++) begin
         @(negedge clk);
         start = 1'b0;
         stop = (off == stop_off);
         injectError = (off == inj_off);
         if (off == abort_off) begin
            chk("edge_high_before_reset", int'(sendEdge), 1);
            mon_hold = 1'b1;
            reset = 1'b0;
         end else if (abort_off >= 0 && off == abort_off + 1) begin
            chk("reset_sendEdge", int'(sendEdge), 0);
            chk("reset_sendData", int'(sendData), 0);
            chk("reset_edgesSent", int'(edgesSent), 0);
            chk("reset_busy", int'(busy), 0);
            chk("reset_queue_drained", evq.size(), 0);
            reset = 1'b1;
            mdl_idx = -1;
            mdl_edges = 0;
            mdl_lvl = 1'b0;
            mdl_inj = 1'b0;
         end
      end
      @(negedge clk);
      stop = 1'b0;
      injectError = 1'b0;
      mon_hold = 1'b0;
   endtask

   task automatic start_with_stop();
      @(negedge clk);
      start = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      repeat (6) @(negedge clk);
      chk("start_stop_busy", int'(busy), 0);
   endtask

   task automatic stop_alone();
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic inject_idle();
      @(negedge clk);
      injectError = 1'b1;
      @(negedge clk);
      injectError = 1'b0;
      if (INJ_EN) mdl_inj = 1'b1;
   endtask

   initial begin
      int so, io, sel, io_max;
      rot[0] = 8'h81;
      rot[1] = 8'h42;
      rot[2] = 8'h24;
      rot[3] = 8'h18;

      repeat (3) @(negedge clk);
      chk("init_sendData", int'(sendData), 0);
      chk("init_sendEdge", int'(sendEdge), 0);
      chk("init_busy", int'(busy), 0);
      chk("init_done", int'(done), 0);
      chk("init_edgesSent", int'(edgesSent), 0);
      reset = 1'b1;
      @(negedge clk);
      mon_hold = 1'b0;

      do_run(-1, -1, -1);
      chk("edges_after_run1", int'(edgesSent), 5);
      do_run(-1, -1, -1);
      chk("edges_after_run2", int'(edgesSent), 10);

      do_run(2 * P + 1, -1, -1);
      chk("data_held_after_stop", int'(sendData), int'(rot[mdl_idx]));

      start_with_stop();
      do_run(-1, -1, -1);

      do_run(-1, -1, (mdl_lvl ? P : 0) + S + 2);
      do_run(2 * P + 1, 1, -1);
      chk("edges_after_inject_run", int'(edgesSent), 3);

      for (int i = 0; i < 12; i++) begin
         sel = $urandom_range(0, 3);
         if (sel == 0) start_with_stop();
         if (sel == 1) stop_alone();
         if (sel == 2) inject_idle();
         so = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, NE * P));
         io_max = (so > 0) ? ((so + P - 1) / P) * P : NE * P;
         if (io_max > NE * P) io_max = NE * P;
         io = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, io_max));
         do_run(so, io, -1);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", evq.size(), 0);
      chk("final_edgesSent", int'(edgesSent), mdl_edges);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/simple_edge_detect_generate.md
# simple_edge_detect_generate

Source-side pattern generator for the CDC edge-detect test pair. It drives an 8-bit data bus plus a toggling edge strobe into the asynchronous boundary. The data bus is held stable around every strobe transition, so the destination-side capture/checker can synchronise the strobe and sample the data safely. The data follows the fixed rotating pattern 0x81 → 0x42 → 0x24 → 0x18 → 0x81 that the checker expects, starting from its post-reset expectation of 0x00.

## Interface
- SETUP_CYCLES, default 4: source cycles data is stable before the strobe toggles; legal range 1–65535.
- HOLD_CYCLES, default 4: source cycles data is held after the strobe toggles before the next data change; legal range 1–65535; must cover ≥3 destination clocks plus margin.
- NUM_EDGES, default 0: edges per run; 0 = continuous until stop.
- clk  input  1  source-domain clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- start  input  1  single-cycle run request; honoured only in IDLE.
- stop  input  1  single-cycle stop request; latched, honoured at end of current period.
- injectError  input  1  single-cycle request to corrupt the next data word (see Configuration).
- sendData  output  8  data word crossing to the destination domain.
- sendEdge  output  1  strobe; each transition marks one valid word.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a run ends.
- edgesSent  output  16  strobe transitions since reset; wraps 0xFFFF → 0x0000.

## Operation
- Reset values: sendData=0x00, sendEdge=0, busy=0, done=0, edgesSent=0, internal pattern=0x00, stop/inject flags clear, state IDLE.
- Next-pattern function: 0x81→0x42, 0x42→0x24, 0x24→0x18, 0x18→0x81, any other→0x81.
- States: IDLE, SETUP, HOLD, DONE.
- IDLE: on start=1 and stop=0: advance pattern, drive sendData=new pattern, counter=SETUP_CYCLES-1, go to SETUP. start=1 with stop=1 in IDLE: no run; pending stop cleared. stop alone in IDLE: ignored.
- SETUP: decrement counter. At 0: toggle sendEdge, increment edgesSent, counter=HOLD_CYCLES-1, go to HOLD.
- HOLD: decrement counter. At 0: if stop is pending, or NUM_EDGES≠0 and edges in this run == NUM_EDGES, go to DONE. Otherwise advance pattern, load sendData, reload SETUP counter, go to SETUP.
- DONE: done=1 for this cycle; clear pending stop and per-run edge count; go to IDLE.
- sendData changes only on the IDLE→SETUP and HOLD→SETUP transitions; never while in SETUP or HOLD.
- Pattern is not reset between runs: a second start continues the sequence, matching the checker, which resets its expectation only on its own reset.
- start while busy: ignored. stop while busy: latched, never aborts mid-period.
- Reset mid-run: all state returns to reset values on that edge. sendEdge may drop 1→0; the destination must be reset at the same time.

## Timing
- start sampled at edge T → sendData valid from T (visible after T), busy=1 after T.
- First sendEdge toggle at edge T+SETUP_CYCLES.
- Next data change at edge T+SETUP_CYCLES+HOLD_CYCLES; period = SETUP_CYCLES+HOLD_CYCLES cycles per word.
- Final HOLD expiry at edge E → done=1 during cycle after E, busy=0 one cycle later.
- edgesSent updates on the same edge as the sendEdge toggle.

## Configuration
- SIMPLE_EDGE_GEN_ERR_INJECT_EN defined:
  - injectError sets a sticky flag.
  - The next data load drives sendData = pattern XOR 0xFF; the flag then clears.
  - The internal pattern advances normally, so subsequent words are correct.
  - injectError during IDLE applies to the first word of the next run.
- Not defined: injectError port present but ignored; no XOR logic; sendData always equals the pattern.

## Test plan
- Reset then start, SETUP=HOLD=4, NUM_EDGES=5 → sendData 0x81,0x42,0x24,0x18,0x81 at 8-cycle spacing; sendEdge toggles 4 cycles after each change; done pulses once; edgesSent=5.
- Second start after that run → first word 0x42 (pattern continues); edgesSent reaches 10.
- NUM_EDGES=0, stop pulsed mid-SETUP of word 3 → word 3's strobe still toggles, HOLD completes, then done; sendData held at 0x24.
- start and stop high in the same IDLE cycle → busy stays 0, no sendData change; a later lone start runs normally.
- Reset (reset=0) during HOLD with sendEdge=1 → next cycle sendEdge=0, sendData=0x00, edgesSent=0, busy=0; a new start emits 0x81.
- With SIMPLE_EDGE_GEN_ERR_INJECT_EN, injectError before the second word → words 0x81,0xBD,0x24; paired checker reports exactly one miscompare {0x42,0xBD}. Without the macro → 0x81,0x42,0x24.
